// File: rtl/pixel_arb_pkg.sv
// rtl/pixel_arb_pkg.sv - shared types and widths for the pixel write arbiter
package pixel_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_CLEAR = 2'd2
  } state_t;

  localparam int SCREEN_W_DEF = 160;
  localparam int SCREEN_H_DEF = 120;
  localparam int X_W = 8;
  localparam int Y_W = 7;
  localparam int C_W = 3;

  // Index/counter width that never collapses to zero bits.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pixel_write_arbiter_rr.sv
// rtl/pixel_write_arbiter_rr.sv - combinational round-robin pick starting at ptr
module rr_arbiter
  import pixel_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] gnt_idx,
  output logic          valid
);

  // First pass covers indices at or after ptr, second pass wraps to the low end.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    valid   = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!valid && req[i] && (PW'(i) >= ptr)) begin
        valid   = 1'b1;
        gnt[i]  = 1'b1;
        gnt_idx = PW'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!valid && req[i]) begin
        valid   = 1'b1;
        gnt[i]  = 1'b1;
        gnt_idx = PW'(i);
      end
    end
  end

endmodule

// File: rtl/pixel_write_arbiter.sv
// rtl/pixel_write_arbiter.sv - grants sprite clients the VGA plot port and runs clear sweeps
module pixel_write_arbiter
  import pixel_arb_pkg::*;
#(
  parameter int N_CLIENTS = 4,
  parameter int SCREEN_W  = SCREEN_W_DEF,
  parameter int SCREEN_H  = SCREEN_H_DEF,
  parameter int MAX_BURST = 64
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [N_CLIENTS-1:0]     req,
  input  logic [N_CLIENTS-1:0]     done,
  input  logic [X_W*N_CLIENTS-1:0] x_in,
  input  logic [Y_W*N_CLIENTS-1:0] y_in,
  input  logic [C_W*N_CLIENTS-1:0] color_in,
  input  logic [N_CLIENTS-1:0]     we_in,
  input  logic                     clear_req,
  output logic [N_CLIENTS-1:0]     busy,
  output logic [N_CLIENTS-1:0]     grant,
  output logic                     clear_done,
  output logic [X_W-1:0]           vga_x,
  output logic [Y_W-1:0]           vga_y,
  output logic [C_W-1:0]           vga_color,
  output logic                     vga_plot
);

  localparam int PW    = idx_w(N_CLIENTS);
  localparam int XC_W  = idx_w(SCREEN_W);
  localparam int YC_W  = idx_w(SCREEN_H);
  localparam int WD_W  = $clog2(MAX_BURST) + 1;
  localparam int XL_W  = X_W + 1;
  localparam int YL_W  = Y_W + 1;

  localparam logic [XC_W-1:0] X_LAST   = XC_W'(SCREEN_W - 1);
  localparam logic [YC_W-1:0] Y_LAST   = YC_W'(SCREEN_H - 1);
  localparam logic [XL_W-1:0] X_LIM    = XL_W'(SCREEN_W);
  localparam logic [YL_W-1:0] Y_LIM    = YL_W'(SCREEN_H);
  localparam logic [WD_W-1:0] WD_LAST  = WD_W'(MAX_BURST - 1);
  localparam logic [PW-1:0]   IDX_LAST = PW'(N_CLIENTS - 1);

  state_t               state, state_next;
  logic [N_CLIENTS-1:0] grant_q;
  logic [PW-1:0]        owner_q;
  logic [PW-1:0]        rr_ptr;
  logic [WD_W-1:0]      wd;
  logic [XC_W-1:0]      sx;
  logic [YC_W-1:0]      sy;
  logic                 clear_pend;
  logic                 last_q;

  logic [N_CLIENTS-1:0] arb_gnt;
  logic [PW-1:0]        arb_idx;
  logic                 arb_valid;

  logic                 own_req, own_done, own_we;
  logic [X_W-1:0]       own_x;
  logic [Y_W-1:0]       own_y;
  logic [C_W-1:0]       own_c;
  logic                 own_in_range;
  logic                 release_now;
  logic                 sweep_last;
  logic                 clear_go;

  rr_arbiter #(.N(N_CLIENTS), .PW(PW)) u_rr (
    .req     (req),
    .ptr     (rr_ptr),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .valid   (arb_valid)
  );

  always_comb begin
    own_req  = 1'b0;
    own_done = 1'b0;
    own_we   = 1'b0;
    own_x    = '0;
    own_y    = '0;
    own_c    = '0;
    for (int i = 0; i < N_CLIENTS; i++) begin
      if (owner_q == PW'(i)) begin
        own_req  = req[i];
        own_done = done[i];
        own_we   = we_in[i];
        own_x    = x_in[X_W*i +: X_W];
        own_y    = y_in[Y_W*i +: Y_W];
        own_c    = color_in[C_W*i +: C_W];
      end
    end
  end

  // Out-of-range pixels are dropped outright rather than clipped to the edge.
  assign own_in_range = ({1'b0, own_x} < X_LIM) && ({1'b0, own_y} < Y_LIM);
  assign sweep_last   = (sx == X_LAST) && (sy == Y_LAST);
  assign clear_go     = clear_req || clear_pend;

  always_comb begin
    state_next  = state;
    release_now = 1'b0;
    case (state)
      S_IDLE: begin
        if (clear_go) begin
          state_next = S_CLEAR;
        end else if (arb_valid) begin
          state_next = S_GRANT;
        end
      end
      S_GRANT: begin
        release_now = own_done || !own_req || (wd == WD_LAST);
        if (release_now) begin
          state_next = S_IDLE;
        end
      end
      S_CLEAR: begin
        if (sweep_last) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= S_IDLE;
      grant_q    <= '0;
      owner_q    <= '0;
      rr_ptr     <= '0;
      wd         <= '0;
      sx         <= '0;
      sy         <= '0;
      clear_pend <= 1'b0;
      last_q     <= 1'b0;
      clear_done <= 1'b0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_color  <= '0;
      vga_plot   <= 1'b0;
    end else begin
      state      <= state_next;
      vga_plot   <= 1'b0;
      last_q     <= 1'b0;
      clear_done <= last_q;
      case (state)
        S_IDLE: begin
          wd <= '0;
          if (clear_go) begin
            clear_pend <= 1'b0;
            sx         <= '0;
            sy         <= '0;
          end else if (arb_valid) begin
            grant_q <= arb_gnt;
            owner_q <= arb_idx;
          end
        end
        S_GRANT: begin
          vga_x     <= own_x;
          vga_y     <= own_y;
          vga_color <= own_c;
          vga_plot  <= own_we && own_in_range;
          if (clear_req) begin
            clear_pend <= 1'b1;
          end
          if (release_now) begin
            grant_q <= '0;
            wd      <= '0;
            rr_ptr  <= (owner_q == IDX_LAST) ? '0 : owner_q + 1'b1;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        S_CLEAR: begin
          vga_x     <= X_W'(sx);
          vga_y     <= Y_W'(sy);
          vga_color <= '0;
          vga_plot  <= 1'b1;
          if (sx == X_LAST) begin
            sx <= '0;
            if (sy == Y_LAST) begin
              sy     <= '0;
              last_q <= 1'b1;
            end else begin
              sy <= sy + 1'b1;
            end
          end else begin
            sx <= sx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign grant = grant_q;
  assign busy  = ~grant_q;

endmodule

// File: tb/tb_pixel_write_arbiter.sv
// tb/tb_pixel_write_arbiter.sv - self-checking bench for pixel_write_arbiter
module tb_pixel_write_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic [3:0]  req, done, we_in, busy, grant;
  logic [31:0] x_in;
  logic [27:0] y_in;
  logic [11:0] color_in;
  logic        clear_req, clear_done, vga_plot;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_color;

  pixel_write_arbiter dut (
    .clk(clk), .resetn(resetn), .req(req), .done(done), .x_in(x_in), .y_in(y_in),
    .color_in(color_in), .we_in(we_in), .clear_req(clear_req), .busy(busy), .grant(grant),
    .clear_done(clear_done), .vga_x(vga_x), .vga_y(vga_y), .vga_color(vga_color),
    .vga_plot(vga_plot)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int plot_cnt = 0;
  bit clearing = 1'b0;
  bit cd_seen = 1'b0;
  logic [17:0] expq[$];
  int lenq[$];

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(input logic [3:0] want, input string name);
    int n = 0;
    while (grant != want && n < 200) begin
      tick();
      n++;
    end
    chk(grant == want, name, 32'(grant), 32'(want));
  endtask

  task automatic push_sweep;
    for (int yy = 0; yy < 120; yy++)
      for (int xx = 0; xx < 160; xx++)
        expq.push_back({8'(xx), 7'(yy), 3'b000});
  endtask

  // Spec-level model: a granted in-range write appears on the plot port one cycle later.
  bit          pred_plot = 1'b0;
  bit          cd_exp = 1'b0;
  logic [3:0]  prev_grant = '0;
  int          run_len = 0;
  always @(negedge clk) begin
    bit cd_now;
    logic [17:0] p;
    if (!resetn) begin
      pred_plot  = 1'b0;
      cd_exp     = 1'b0;
      prev_grant = '0;
      run_len    = 0;
    end else begin
      chk(busy == ~grant, "busy_inv", 32'(busy), 32'(~grant));
      chk($onehot0(grant), "grant_onehot", 32'(grant), 32'(0));
      if (!clearing) chk(vga_plot == pred_plot, "plot_pred", 32'(vga_plot), 32'(pred_plot));
      cd_now = 1'b0;
      if (vga_plot) begin
        plot_cnt++;
        if (expq.size() == 0) begin
          chk(1'b0, "plot_unexpected", {14'd0, vga_x, vga_y, vga_color}, 32'(0));
        end else begin
          p = expq.pop_front();
          chk({vga_x, vga_y, vga_color} == p, "plot_pix", {14'd0, vga_x, vga_y, vga_color}, {14'd0, p});
          if (clearing && expq.size() == 0) cd_now = 1'b1;
        end
      end
      chk(clear_done == cd_exp, "clear_done", 32'(clear_done), 32'(cd_exp));
      if (clear_done) cd_seen = 1'b1;
      cd_exp = cd_now;
      if (grant != prev_grant) begin
        chk(grant == 4'd0 || prev_grant == 4'd0, "idle_gap", 32'(grant), 32'(prev_grant));
        if (prev_grant != 4'd0) lenq.push_back(run_len);
        run_len = 0;
      end
      if (grant != 4'd0) run_len++;
      prev_grant = grant;
      pred_plot = 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (grant[i] && we_in[i] && x_in[8*i +: 8] < 8'd160 && y_in[7*i +: 7] < 7'd120) begin
          pred_plot = 1'b1;
          expq.push_back({x_in[8*i +: 8], y_in[7*i +: 7], color_in[3*i +: 3]});
        end
      end
    end
  end

  initial begin
    logic [3:0] order [5];
    logic [3:0] g;
    int base, n, bad;
    logic [7:0] vx [6];
    logic [6:0] vy [6];
    logic       vw [6];

    order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    vx = '{8'd160, 8'd5, 8'd159, 8'd1, 8'd0, 8'd255};
    vy = '{7'd5, 7'd120, 7'd119, 7'd1, 7'd0, 7'd127};
    vw = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

    resetn = 1'b0; req = '0; done = '0; we_in = '0; x_in = '0; y_in = '0;
    color_in = '0; clear_req = 1'b0;
    repeat (3) tick();
    chk(grant == 4'd0, "rst_grant", 32'(grant), 32'(0));
    chk(busy == 4'b1111, "rst_busy", 32'(busy), 32'hf);
    chk({vga_x, vga_y, vga_color, vga_plot, clear_done} == '0, "rst_vga",
        {12'd0, vga_x, vga_y, vga_color, vga_plot, clear_done}, 32'(0));
    resetn = 1'b1;
    tick();

    // Round robin with all clients requesting; stray we/done from non-owners.
    req = 4'b1111; we_in = 4'b1111;
    for (int gi = 0; gi < 5; gi++) begin
      wait_grant(order[gi], "rr_order");
      g = grant;
      for (int k = 0; k < 4; k++) begin
        for (int i = 0; i < 4; i++) begin
          x_in[8*i +: 8]     = 8'(20*i + 5*gi + k);
          y_in[7*i +: 7]     = 7'(10 + i + k);
          color_in[3*i +: 3] = 3'(i + k);
        end
        done = (k == 3) ? g : ((k == 0) ? ~g : 4'b0000);
        tick();
      end
      done = '0;
    end
    req = '0; we_in = '0;
    repeat (2) tick();
    chk(lenq.size() == 5, "rr_bursts", 32'(lenq.size()), 32'd5);
    while (lenq.size() > 0) begin
      n = lenq.pop_front();
      chk(n == 4, "rr_len", 32'(n), 32'd4);
    end

    // Single client, 12 writes at (10,20,4).
    base = plot_cnt;
    req = 4'b0001;
    wait_grant(4'b0001, "c0_grant");
    chk(busy == 4'b1110, "c0_busy", 32'(busy), 32'he);
    x_in[7:0] = 8'd10; y_in[6:0] = 7'd20; color_in[2:0] = 3'b100;
    for (int k = 0; k < 12; k++) begin
      we_in = 4'b0001;
      done  = (k == 11) ? 4'b0001 : 4'b0000;
      tick();
    end
    we_in = '0; done = '0; req = '0;
    chk(grant == 4'd0, "c0_release", 32'(grant), 32'(0));
    repeat (3) tick();
    chk(plot_cnt - base == 12, "c0_plots", 32'(plot_cnt - base), 32'd12);
    chk(lenq.size() > 0 && lenq[lenq.size()-1] == 12, "c0_len", 32'(lenq.size()), 32'd12);
    lenq.delete();

    // Range boundaries on client 1 while others strobe in-range pixels.
    base = plot_cnt;
    for (int i = 0; i < 4; i++) begin
      x_in[8*i +: 8] = 8'd1; y_in[7*i +: 7] = 7'd1; color_in[3*i +: 3] = 3'd7;
    end
    req = 4'b0010; we_in = 4'b1101;
    wait_grant(4'b0010, "rng_grant");
    for (int k = 0; k < 6; k++) begin
      x_in[15:8] = vx[k]; y_in[13:7] = vy[k]; color_in[5:3] = 3'(k);
      we_in = {2'b11, vw[k], 1'b1};
      done  = (k == 5) ? 4'b0010 : 4'b0000;
      tick();
    end
    we_in = '0; done = '0; req = '0;
    repeat (3) tick();
    chk(plot_cnt - base == 2, "rng_plots", 32'(plot_cnt - base), 32'd2);

    // Clear beats a simultaneous request; a second clear_req mid-sweep is ignored.
    push_sweep();
    clearing = 1'b1; cd_seen = 1'b0; base = plot_cnt; bad = 0;
    clear_req = 1'b1; req = 4'b0010;
    tick();
    clear_req = 1'b0;
    n = 0;
    while (!cd_seen && n < 19400) begin
      clear_req = (n == 1000);
      if (grant != 4'd0 && !clear_done) bad++;
      tick();
      n++;
    end
    clear_req = 1'b0; clearing = 1'b0;
    chk(cd_seen, "clr_done_seen", 32'(cd_seen), 32'd1);
    chk(plot_cnt - base == 19200, "clr_plots", 32'(plot_cnt - base), 32'd19200);
    chk(expq.size() == 0, "clr_queue", 32'(expq.size()), 32'd0);
    chk(bad == 0, "clr_no_grant", 32'(bad), 32'd0);
    wait_grant(4'b0010, "clr_then_grant");
    done = 4'b0010;
    tick();
    done = '0; req = '0;
    repeat (2) tick();

    // Watchdog: client 2 never finishes, client 0 takes over after 64 cycles.
    req = 4'b0101;
    wait_grant(4'b0100, "wd_grant");
    n = 0;
    while (grant == 4'b0100 && n < 200) begin
      tick();
      n++;
    end
    chk(n == 64, "wd_cycles", 32'(n), 32'd64);
    wait_grant(4'b0001, "wd_next");
    req = '0;
    tick();
    chk(grant == 4'd0, "req_drop_release", 32'(grant), 32'(0));
    repeat (2) tick();

    // Clear requested mid-burst is served after release; reset aborts it at pixel 500.
    req = 4'b1000;
    wait_grant(4'b1000, "pend_grant");
    push_sweep();
    clearing = 1'b1; cd_seen = 1'b0; base = plot_cnt;
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    tick();
    done = 4'b1000;
    tick();
    done = '0; req = '0;
    n = 0;
    while (plot_cnt - base < 500 && n < 2000) begin
      tick();
      n++;
    end
    chk(plot_cnt - base == 500, "pend_sweep", 32'(plot_cnt - base), 32'd500);
    chk(grant == 4'd0, "pend_no_grant", 32'(grant), 32'(0));
    resetn = 1'b0;
    tick();
    chk(grant == 4'd0, "abort_grant", 32'(grant), 32'(0));
    chk(vga_plot == 1'b0, "abort_plot", 32'(vga_plot), 32'(0));
    chk(busy == 4'b1111, "abort_busy", 32'(busy), 32'hf);
    chk(clear_done == 1'b0, "abort_cd", 32'(clear_done), 32'(0));
    resetn = 1'b1;
    expq.delete();
    clearing = 1'b0;
    req = 4'b1010;
    wait_grant(4'b0010, "post_rst_rr");
    done = 4'b0010;
    tick();
    done = '0; req = '0;
    repeat (4) tick();
    chk(!cd_seen, "abort_no_cd", 32'(cd_seen), 32'(0));
    chk(expq.size() == 0, "final_queue", 32'(expq.size()), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
